// File: rtl/sng_pkg.sv
// -----------------------------------------------------------------------------
// sng_pkg
// Shared types and constant helpers for the stochastic number generator bank:
//   - state_e     : generator FSM states
//   - lfsr_taps   : maximal-length Galois tap masks for widths 4..16
//   - width_mask  : all-ones mask of a given width
//   - lfsr_seed   : per-channel LFSR seed derivation
//   - bitrev      : reverse the low `len` bits of a value
// -----------------------------------------------------------------------------
package sng_pkg;

  localparam int unsigned MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Right-shifting Galois masks; bit k set means polynomial term x^(k+1).
  function automatic logic [MAX_W-1:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      default: return 16'hB400;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
    return (width >= MAX_W) ? '1 : MAX_W'((32'd1 << width) - 32'd1);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so a zero seed becomes 1.
  function automatic logic [MAX_W-1:0] lfsr_seed(input int unsigned     width,
                                                 input logic [MAX_W-1:0] base,
                                                 input int unsigned     ch);
    logic [31:0]      prod;
    logic [MAX_W-1:0] s;
    prod = ch * 32'h3B;
    s    = (base ^ prod[MAX_W-1:0]) & width_mask(width);
    return (s == '0) ? 16'h0001 : s;
  endfunction

  // Full 16-bit reversal, then shift so that only the low `len` bits of v
  // end up reversed in the low `len` bits of the result.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v,
                                              input logic [4:0]       len);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = v[MAX_W-1-i];
    return r >> (5'(MAX_W) - len);
  endfunction

endpackage

// File: rtl/sng_lfsr.sv
// -----------------------------------------------------------------------------
// sng_lfsr
// One right-shifting Galois LFSR.
//   clk_i   : clock (rising edge)
//   rst_ni  : asynchronous active-low reset, loads SEED
//   load_i  : reload SEED on the next edge (has priority over step_i)
//   step_i  : advance one position on the next edge
//   next_o  : value the register takes on the next edge (lets the parent
//             compute registered outputs from the upcoming state)
// -----------------------------------------------------------------------------
module sng_lfsr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] state_q, state_d, stepped;

  always_comb begin
    stepped = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    // NOTE: default assignment first so every path drives state_d (no latch).
    state_d = state_q;
    if (load_i)      state_d = SEED;
    else if (step_i) state_d = stepped;
  end

  // NOTE: non-blocking in clocked blocks so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEED;
    else         state_q <= state_d;
  end

  assign next_o = state_d;

endmodule

// File: rtl/sng_bank.sv
// -----------------------------------------------------------------------------
// sng_bank
// DIM-channel binary-to-stochastic converter. Operands are accepted on a
// valid/ready handshake; each channel then emits one registered bit per cycle
// for 2^L cycles, bit = (truncated operand > r), where r is a bit-reversed
// counter or the top L bits of a per-channel Galois LFSR.
//   i_clk_sng_bank / i_rst_n_sng_bank : clock, async active-low reset
//   i_x_bn            : DIM operands, NUM_BIT each (two's complement if bipolar)
//   i_valid_sng_bank  : operands valid     o_ready_sng_bank : can accept
//   i_len_log2        : L (0 or > NUM_BIT means NUM_BIT), sampled at accept
//   i_mode_rng        : 0 counter, 1 LFSR   i_bipolar : bipolar encoding
//   i_stop_sng_bank   : abort stream / block acceptance
//   o_isgen, o_last, o_sn_bit : stream valid, final bit, per-channel bits
// -----------------------------------------------------------------------------
module sng_bank
  import sng_pkg::*;
#(
  parameter int unsigned        NUM_BIT = 8,
  parameter int unsigned        DIM     = 4,
  parameter logic [MAX_W-1:0]   SEED    = 16'h005A,
  localparam int unsigned       LW      = $clog2(NUM_BIT + 1)
) (
  input  logic                          i_clk_sng_bank,
  input  logic                          i_rst_n_sng_bank,
  input  logic [DIM-1:0][NUM_BIT-1:0]   i_x_bn,
  input  logic                          i_valid_sng_bank,
  output logic                          o_ready_sng_bank,
  input  logic [LW-1:0]                 i_len_log2,
  input  logic                          i_mode_rng,
  input  logic                          i_bipolar,
  input  logic                          i_stop_sng_bank,
  output logic                          o_isgen,
  output logic                          o_last,
  output logic [DIM-1:0]                o_sn_bit
);

  localparam logic [MAX_W-1:0]   TAPS16 = lfsr_taps(NUM_BIT);
  localparam logic [NUM_BIT-1:0] TAPS   = TAPS16[NUM_BIT-1:0];
  localparam logic [NUM_BIT-1:0] HALF   = {1'b1, {(NUM_BIT-1){1'b0}}};
  localparam logic [NUM_BIT-1:0] ONE    = 1;

  state_e                      state_q;
  logic [DIM-1:0][NUM_BIT-1:0] xt_q, xt_d, xu;
  logic [4:0]                  len_q, len_d, len_in, shift_d;
  logic                        mode_q, mode_d;
  logic [NUM_BIT-1:0]          cnt_q, cnt_d, cnt_max_d;
  logic                        accept, advance, gen_d, last_d;
  logic [DIM-1:0]              bit_d;
  logic [DIM-1:0][NUM_BIT-1:0] lfsr_next;
  logic [MAX_W-1:0]            rev16;
  logic [DIM-1:0][MAX_W-1:0]   r16;

  // Stop blocks acceptance; a stop on the last GEN cycle has no effect
  // because that edge already ends the stream.
  assign accept  = i_valid_sng_bank & o_ready_sng_bank & ~i_stop_sng_bank;
  assign advance = (state_q == GEN) & ~o_last & ~i_stop_sng_bank;
  assign gen_d   = accept | advance;

  // Everything below is the value for the *next* cycle, so the output flops
  // can be loaded on the same edge that latches operands or advances state.
  always_comb begin
    len_in = 5'(i_len_log2);
    if (len_in == 5'd0 || len_in > 5'(NUM_BIT)) len_in = 5'(NUM_BIT);

    len_d     = accept ? len_in : len_q;
    mode_d    = accept ? i_mode_rng : mode_q;
    shift_d   = 5'(NUM_BIT) - len_d;
    cnt_d     = accept ? '0 : (advance ? cnt_q + ONE : cnt_q);
    cnt_max_d = {NUM_BIT{1'b1}} >> shift_d;
    last_d    = gen_d & (cnt_d == cnt_max_d);
    rev16     = bitrev(MAX_W'(cnt_d), len_d);

    for (int c = 0; c < DIM; c++) begin
      // Adding 2^(NUM_BIT-1) maps two's complement onto offset binary.
      xu[c]    = i_bipolar ? i_x_bn[c] + HALF : i_x_bn[c];
      xt_d[c]  = accept ? (xu[c] >> shift_d) : xt_q[c];
      r16[c]   = mode_d ? MAX_W'(lfsr_next[c] >> shift_d) : rev16;
      bit_d[c] = gen_d & (MAX_W'(xt_d[c]) > r16[c]);
    end
  end

  for (genvar c = 0; c < DIM; c++) begin : g_lfsr
    localparam logic [MAX_W-1:0] SEED16 = lfsr_seed(NUM_BIT, SEED, c);
    sng_lfsr #(
      .WIDTH (NUM_BIT),
      .TAPS  (TAPS),
      .SEED  (SEED16[NUM_BIT-1:0])
    ) u_lfsr (
      .clk_i  (i_clk_sng_bank),
      .rst_ni (i_rst_n_sng_bank),
      .load_i (accept),
      .step_i (advance),
      .next_o (lfsr_next[c])
    );
  end

  always_ff @(posedge i_clk_sng_bank or negedge i_rst_n_sng_bank) begin
    if (!i_rst_n_sng_bank) begin
      state_q          <= IDLE;
      o_ready_sng_bank <= 1'b1;
      o_isgen          <= 1'b0;
      o_last           <= 1'b0;
      o_sn_bit         <= '0;
      cnt_q            <= '0;
      xt_q             <= '0;
      len_q            <= 5'(NUM_BIT);
      mode_q           <= 1'b0;
    end else begin
      o_isgen  <= gen_d;
      o_last   <= last_d;
      o_sn_bit <= bit_d;
      cnt_q    <= cnt_d;
      xt_q     <= xt_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q          <= GEN;
            o_ready_sng_bank <= 1'b0;
          end else begin
            state_q          <= IDLE;
            o_ready_sng_bank <= 1'b1;
          end
        end
        GEN: begin
          if (o_last || i_stop_sng_bank) begin
            state_q          <= DONE;
            o_ready_sng_bank <= 1'b1;
          end
        end
        default: begin
          state_q          <= IDLE;
          o_ready_sng_bank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sng_bank.sv
// -----------------------------------------------------------------------------
// tb_sng_bank
// Directed self-checking bench for sng_bank (NUM_BIT=8, DIM=4). Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sng_bank;

  localparam int NB = 8;
  localparam int D  = 4;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [D-1:0][NB-1:0] i_x_bn = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [LW-1:0]     i_len_log2 = '0;
  logic              i_mode_rng = 1'b0;
  logic              i_bipolar = 1'b0;
  logic              i_stop = 1'b0;
  logic              o_isgen;
  logic              o_last;
  logic [D-1:0]      o_sn_bit;

  int total = 0;
  int bad   = 0;
  int n_gen, last_cnt, last_pos, rdy_bad, lfsr_err;
  int ones [D];
  logic [NB-1:0] xref [D];
  logic [NB-1:0] m    [D];

  always #5 clk = ~clk;

  sng_bank dut (
    .i_clk_sng_bank   (clk),
    .i_rst_n_sng_bank (rst_n),
    .i_x_bn           (i_x_bn),
    .i_valid_sng_bank (i_valid),
    .o_ready_sng_bank (o_ready),
    .i_len_log2       (i_len_log2),
    .i_mode_rng       (i_mode_rng),
    .i_bipolar        (i_bipolar),
    .i_stop_sng_bank  (i_stop),
    .o_isgen          (o_isgen),
    .o_last           (o_last),
    .o_sn_bit         (o_sn_bit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference seeds: 8'h5A ^ (c * 8'h3B).
  task automatic seed_model();
    m[0] = 8'h5A; m[1] = 8'h61; m[2] = 8'h2C; m[3] = 8'hEB;
  endtask

  // Called on a falling edge; returns on the falling edge of the first
  // stream cycle (one rising edge after valid is presented).
  task automatic start(input logic [NB-1:0] x0, x1, x2, x3,
                       input logic [LW-1:0] len, input logic mode, input logic bip);
    xref[0] = x0; xref[1] = x1; xref[2] = x2; xref[3] = x3;
    i_x_bn     = {x3, x2, x1, x0};
    i_len_log2 = len;
    i_mode_rng = mode;
    i_bipolar  = bip;
    i_valid    = 1'b1;
    @(negedge clk);
    i_valid    = 1'b0;
  endtask

  // Walks the stream while o_isgen is high (bounded), gathering statistics.
  // Returns on the falling edge of the first cycle with o_isgen low.
  task automatic run_stream(input int stop_at, input bit chk_lfsr);
    n_gen = 0; last_cnt = 0; last_pos = 0; rdy_bad = 0; lfsr_err = 0;
    for (int c = 0; c < D; c++) ones[c] = 0;
    for (int k = 0; k < 400; k++) begin
      if (o_isgen !== 1'b1) break;
      n_gen++;
      for (int c = 0; c < D; c++) ones[c] += int'(o_sn_bit[c]);
      if (o_last === 1'b1) begin
        last_cnt++;
        last_pos = n_gen;
      end
      if (o_ready !== 1'b0) rdy_bad++;
      if (chk_lfsr) begin
        for (int c = 0; c < D; c++) begin
          if (o_sn_bit[c] !== (xref[c] > m[c])) lfsr_err++;
          m[c] = m[c][0] ? ((m[c] >> 1) ^ 8'hB8) : (m[c] >> 1);
        end
      end
      if (n_gen == stop_at) i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_isgen"}, 32'(o_isgen), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_sn"},    32'(o_sn_bit), 32'd0);
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    check("post_reset_last", 32'(o_last), 32'd0);

    // Counter, unipolar, L=8.
    start(8'd1, 8'd2, 8'd3, 8'd4, 4'd8, 1'b0, 1'b0);
    run_stream(0, 1'b0);
    check("cnt8_len", n_gen, 256);
    check("cnt8_ones0", ones[0], 1);
    check("cnt8_ones1", ones[1], 2);
    check("cnt8_ones2", ones[2], 3);
    check("cnt8_ones3", ones[3], 4);
    check("cnt8_last_cnt", last_cnt, 1);
    check("cnt8_last_pos", last_pos, 256);
    check("cnt8_ready_low", rdy_bad, 0);
    check_idle("cnt8_done");

    // Counter, L=4, operands truncated to their top 4 bits.
    start(8'h80, 8'hFF, 8'h0F, 8'h00, 4'd4, 1'b0, 1'b0);
    run_stream(0, 1'b0);
    check("cnt4_len", n_gen, 16);
    check("cnt4_ones0", ones[0], 8);
    check("cnt4_ones1", ones[1], 15);
    check("cnt4_ones2", ones[2], 0);
    check("cnt4_ones3", ones[3], 0);
    check("cnt4_last_pos", last_pos, 16);

    // Bipolar, L=8.
    start(8'h00, 8'h80, 8'h7F, 8'hC0, 4'd8, 1'b0, 1'b1);
    run_stream(0, 1'b0);
    check("bip_len", n_gen, 256);
    check("bip_ones0", ones[0], 128);
    check("bip_ones1", ones[1], 0);
    check("bip_ones2", ones[2], 255);
    check("bip_ones3", ones[3], 64);

    // L=0 is treated as NUM_BIT.
    start(8'd1, 8'd2, 8'd3, 8'd4, 4'd0, 1'b0, 1'b0);
    run_stream(0, 1'b0);
    check("l0_len", n_gen, 256);
    check("l0_ones3", ones[3], 4);

    // Stop on GEN cycle 10.
    start(8'd1, 8'd2, 8'd3, 8'd4, 4'd8, 1'b0, 1'b0);
    run_stream(10, 1'b0);
    check("stop_len", n_gen, 10);
    check("stop_no_last", last_cnt, 0);
    check_idle("stop_done");

    // Stop on the final cycle still shows o_last.
    start(8'd1, 8'd2, 8'd3, 8'd4, 4'd4, 1'b0, 1'b0);
    run_stream(16, 1'b0);
    check("stoplast_len", n_gen, 16);
    check("stoplast_last", last_cnt, 1);

    // Valid together with stop (first in DONE, then in IDLE) is refused.
    i_valid = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    check_idle("vstop_1");
    @(negedge clk);
    check_idle("vstop_2");
    i_valid = 1'b0;
    i_stop  = 1'b0;
    @(negedge clk);

    // LFSR mode, bit-exact against the reference, then back-to-back.
    seed_model();
    start(8'd0, 8'd255, 8'd128, 8'd64, 4'd8, 1'b1, 1'b0);
    run_stream(0, 1'b1);
    check("lfsr_len", n_gen, 256);
    check("lfsr_bits", lfsr_err, 0);
    check("lfsr_ones0", ones[0], 0);
    check("lfsr_last_pos", last_pos, 256);
    check_idle("lfsr_gap");
    seed_model();
    start(8'd0, 8'd255, 8'd128, 8'd64, 4'd8, 1'b1, 1'b0);
    check("b2b_isgen", 32'(o_isgen), 32'd1);
    run_stream(0, 1'b1);
    check("b2b_len", n_gen, 256);
    check("b2b_bits", lfsr_err, 0);

    // Asynchronous reset in the middle of a stream.
    start(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd8, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_isgen", 32'(o_isgen), 32'd1);
    check("pre_rst_sn", 32'(o_sn_bit), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_last", 32'(o_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_async_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sng_bank.md
Name: sng_bank

Overview:
- Parametrised multi-channel binary-to-stochastic number generator; successor to the fixed-width FSM-driven mux generator.
- Accepts DIM binary operands through a valid/ready handshake and emits one registered stochastic bit per channel per cycle for a programmable stream length of 2^L.
- Supports deterministic (bit-reversed counter) and pseudo-random (LFSR) sources, plus unipolar/bipolar encoding.
- Sits in nn_wraper, directly ahead of the stochastic MAC array.

Parameters:
- NUM_BIT, 8, operand width; max stream length 2^NUM_BIT (legal range 4..16).
- DIM, 4, channel count.
- SEED, 8'h5A zero-extended to NUM_BIT, base LFSR seed. Channel c seed = SEED ^ (c*8'h3B); forced to 1 if the result is 0.

Ports:
- i_clk_sng_bank, in, 1, clock (rising edge).
- i_rst_n_sng_bank, in, 1, reset: asynchronous assert, active-low.
- i_x_bn, in, NUM_BIT x DIM, operands; unsigned in unipolar mode, two's complement in bipolar mode.
- i_valid_sng_bank, in, 1, operand valid.
- o_ready_sng_bank, out, 1, block can accept operands.
- i_len_log2, in, clog2(NUM_BIT+1), L = log2 of stream length; sampled at accept.
- i_mode_rng, in, 1, 0 = bit-reversed counter, 1 = LFSR; sampled at accept.
- i_bipolar, in, 1, 1 = bipolar encoding; sampled at accept.
- i_stop_sng_bank, in, 1, abort current stream.
- o_isgen, out, 1, o_sn_bit is valid this cycle.
- o_last, out, 1, final bit of the stream.
- o_sn_bit, out, DIM, one stochastic bit per channel.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; o_ready=1; o_isgen=0; o_last=0; o_sn_bit=0; counter=0; LFSRs loaded with their per-channel seeds.
- FSM states: IDLE, GEN, DONE.
- IDLE -> GEN on (valid & ready & !stop) at edge T.
  - At that edge: latch x, L, mode and bipolar; clear the cycle counter; reseed the LFSRs.
  - Clamp L: L=0 or L>NUM_BIT is treated as NUM_BIT.
- GEN: one bit per channel per cycle.
  - Outputs are registered. The first bit appears in cycle T+1 with o_isgen=1.
  - The stream lasts exactly 2^L cycles, T+1 .. T+2^L.
  - o_last=1 only in cycle T+2^L. GEN -> DONE at that edge.
- DONE: o_isgen=0, o_ready=1. Returns to IDLE, or accepts new operands in the same cycle (back-to-back streams, no gap beyond one cycle).
- o_ready=0 throughout GEN. i_valid is ignored while o_ready=0.
- Bipolar operand transform: xu = x + 2^(NUM_BIT-1) mod 2^NUM_BIT. Unipolar: xu = x.
- Truncated operand: xt = xu >> (NUM_BIT-L), L bits wide.
- Counter mode: r = bitrev_L(cnt[L-1:0]). Bit = (xt > r). The stream holds exactly xt ones.
- LFSR mode: r = top L bits of the channel's Galois LFSR. Bit = (xt > r). The LFSR advances once per GEN cycle.
- i_stop in GEN: the next cycle has o_isgen=0 and o_last=0, then DONE. A partial stream never raises o_last.
- i_stop together with valid in IDLE or DONE: stop wins, nothing is accepted.
- Stop on the last GEN cycle: o_last still asserts that cycle; stop has no further effect.
- Reset mid-stream: all outputs return to reset values immediately (asynchronous).
- Whenever o_isgen=0, o_sn_bit=0.

Decomposition:
- Package sng_pkg:
  - state enum (IDLE/GEN/DONE);
  - LFSR tap-polynomial table indexed by NUM_BIT (maximal-length, 4..16);
  - bitrev function;
  - seed-derivation function.
- Sub-module sng_lfsr:
  - one Galois LFSR with parameters WIDTH and TAPS;
  - inputs: load (with seed) and step enables;
  - instantiated DIM times via generate.

Test Plan (NUM_BIT=8, DIM=4):
- Reset held low for 3 cycles, then released -> o_ready=1, o_isgen=0, o_sn_bit=0. Asserting reset while in GEN forces the same values without waiting for a clock edge.
- Counter mode, unipolar, L=8, x={1,2,3,4} -> 256 cycles with o_isgen=1; ones counts per channel = 1,2,3,4; o_last only on bit 256; o_ready=0 during GEN, then 1.
- Counter mode, L=4, x={0x80,0xFF,0x0F,0x00} -> 16-bit streams with ones = 8,15,0,0.
- Bipolar, L=8, x={0x00,0x80,0x7F,0xC0} (0,-128,127,-64) -> ones = 128,0,255,64.
- Stop asserted on GEN cycle 10 -> o_isgen=0 from cycle 11, o_last never asserts. Valid+stop together in IDLE -> not accepted.
- LFSR mode, L=8, x={0,255,128,64} -> bit-exact match against a reference model using derived seeds. Channel 0 all zeros. A back-to-back second stream starts one cycle after o_last with reseeded LFSRs.
